// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One 64-bit word per line, request/acknowledge memory bus, read hit/miss counters.
module dcache_wt_ctrl #(
    parameter int SETS  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dcache_en,
    input  logic             dcache_wren,
    input  logic [63:0]      dcache_addr,
    input  logic [63:0]      dcache_wdata,
    output logic [63:0]      dcache_rdata,
    output logic             dcache_done,
    output logic             bus_req,
    output logic             bus_wren,
    output logic [63:0]      bus_addr,
    output logic [63:0]      bus_wdata,
    input  logic             bus_ack,
    input  logic [63:0]      bus_rdata,
    output logic [CNT_W-1:0] rd_hit_cnt,
    output logic [CNT_W-1:0] rd_miss_cnt
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 64 - 3 - IDX;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t             state_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [63:0]        data_arr [SETS];

    logic [63:0]        dcache_rdata_q;
    logic               dcache_done_q;
    logic               bus_req_q;
    logic               bus_wren_q;
    logic [63:0]        bus_addr_q;
    logic [63:0]        bus_wdata_q;
    logic [CNT_W-1:0]   rd_hit_cnt_q;
    logic [CNT_W-1:0]   rd_miss_cnt_q;

    logic [IDX-1:0]     req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [63:0]        req_addr_aligned;
    logic               req_hit;
    logic [IDX-1:0]     fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               wr_hit_we;
    logic               fill_we;
    logic               unused_addr_lsbs;

    assign req_idx          = dcache_addr[3 +: IDX];
    assign req_tag          = dcache_addr[63 -: TAG_W];
    assign req_addr_aligned = {dcache_addr[63:3], 3'b000};
    assign req_hit          = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign unused_addr_lsbs = ^dcache_addr[2:0];

    // The outstanding miss address is held in bus_addr_q, so it also names the line to fill.
    assign fill_idx  = bus_addr_q[3 +: IDX];
    assign fill_tag  = bus_addr_q[63 -: TAG_W];
    assign wr_hit_we = !reset && (state_q == IDLE) && dcache_en && dcache_wren && req_hit;
    assign fill_we   = !reset && (state_q == RD_MISS) && bus_ack;

    // NOTE: tag/data arrays have no reset; valid_q alone decides whether their contents count.
    always_ff @(posedge clk) begin
        if (wr_hit_we) begin
            data_arr[req_idx] <= dcache_wdata;
        end else if (fill_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= bus_rdata;
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            dcache_rdata_q <= '0;
            dcache_done_q  <= 1'b0;
            bus_req_q      <= 1'b0;
            bus_wren_q     <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            rd_hit_cnt_q   <= '0;
            rd_miss_cnt_q  <= '0;
        end else begin
            dcache_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dcache_en) begin
                        if (dcache_wren) begin
                            bus_req_q   <= 1'b1;
                            bus_wren_q  <= 1'b1;
                            bus_addr_q  <= req_addr_aligned;
                            bus_wdata_q <= dcache_wdata;
                            state_q     <= WR_THRU;
                        end else if (req_hit) begin
                            dcache_rdata_q <= data_arr[req_idx];
                            dcache_done_q  <= 1'b1;
                            rd_hit_cnt_q   <= rd_hit_cnt_q + CNT_W'(1);
                        end else begin
                            bus_req_q     <= 1'b1;
                            bus_wren_q    <= 1'b0;
                            bus_addr_q    <= req_addr_aligned;
                            rd_miss_cnt_q <= rd_miss_cnt_q + CNT_W'(1);
                            state_q       <= RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (bus_ack) begin
                        valid_q[fill_idx] <= 1'b1;
                        dcache_rdata_q    <= bus_rdata;
                        dcache_done_q     <= 1'b1;
                        bus_req_q         <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (bus_ack) begin
                        dcache_rdata_q <= bus_wdata_q;
                        dcache_done_q  <= 1'b1;
                        bus_req_q      <= 1'b0;
                        bus_wren_q     <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dcache_rdata = dcache_rdata_q;
    assign dcache_done  = dcache_done_q;
    assign bus_req      = bus_req_q;
    assign bus_wren     = bus_wren_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign rd_hit_cnt   = rd_hit_cnt_q;
    assign rd_miss_cnt  = rd_miss_cnt_q;

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Directed, table-driven bench for dcache_wt_ctrl (SETS = 64, CNT_W = 32).
// Vectors carry hand-computed expectations; reset-abort and busy-ignore cases are hand-written.
module tb_dcache_wt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_en;
    logic        dcache_wren;
    logic [63:0] dcache_addr;
    logic [63:0] dcache_wdata;
    logic [63:0] dcache_rdata;
    logic        dcache_done;
    logic        bus_req;
    logic        bus_wren;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic [31:0] rd_hit_cnt;
    logic [31:0] rd_miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dcache_wt_ctrl #(.SETS(64), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .dcache_en    (dcache_en),
        .dcache_wren  (dcache_wren),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_done  (dcache_done),
        .bus_req      (bus_req),
        .bus_wren     (bus_wren),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .rd_hit_cnt   (rd_hit_cnt),
        .rd_miss_cnt  (rd_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          delay;
        logic [63:0] bus_data;
        logic        exp_bus;
        logic [63:0] exp_rdata;
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        @(negedge clk);
        dcache_en    = 1'b1;
        dcache_wren  = v.wr;
        dcache_addr  = v.addr;
        dcache_wdata = v.wdata;
        @(negedge clk);
        dcache_en = 1'b0;
        check($sformatf("v%0d bus_req", k), bus_req, v.exp_bus);
        if (v.exp_bus) begin
            check($sformatf("v%0d bus_addr", k), bus_addr, v.addr & ~64'h7);
            check($sformatf("v%0d bus_wren", k), bus_wren, v.wr);
            if (v.wr) check($sformatf("v%0d bus_wdata", k), bus_wdata, v.wdata);
            check($sformatf("v%0d early_done", k), dcache_done, 1'b0);
            for (int i = 1; i < v.delay; i++) begin
                @(negedge clk);
                check($sformatf("v%0d req_held", k), bus_req, 1'b1);
                check($sformatf("v%0d addr_held", k), bus_addr, v.addr & ~64'h7);
            end
            bus_ack   = 1'b1;
            bus_rdata = v.bus_data;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            check($sformatf("v%0d req_drop", k), bus_req, 1'b0);
        end
        check($sformatf("v%0d done", k), dcache_done, 1'b1);
        check($sformatf("v%0d rdata", k), dcache_rdata, v.exp_rdata);
        check($sformatf("v%0d hit_cnt", k), rd_hit_cnt, v.exp_hit);
        check($sformatf("v%0d miss_cnt", k), rd_miss_cnt, v.exp_miss);
        @(negedge clk);
        check($sformatf("v%0d done_drop", k), dcache_done, 1'b0);
    endtask

    initial begin
        int done_seen;
        // Index = addr[8:3]: 0x0, 0x200, 0x1000 share line 0; 0x2008 and 0x1008 share line 1.
        //          wr    addr          wdata  dly bus_data       bus   rdata          hit miss
        vecs[0]  = '{1'b0, 64'h1000, 64'h0,  3, 64'hDEADBEEF, 1'b1, 64'hDEADBEEF, 0, 1};
        vecs[1]  = '{1'b0, 64'h1004, 64'h0,  0, 64'h0,        1'b0, 64'hDEADBEEF, 1, 1};
        vecs[2]  = '{1'b1, 64'h1000, 64'h55, 2, 64'h0,        1'b1, 64'h55,       1, 1};
        vecs[3]  = '{1'b0, 64'h1000, 64'h0,  0, 64'h0,        1'b0, 64'h55,       2, 1};
        vecs[4]  = '{1'b1, 64'h2008, 64'h77, 1, 64'h0,        1'b1, 64'h77,       2, 1};
        vecs[5]  = '{1'b0, 64'h2008, 64'h0,  2, 64'h1234,     1'b1, 64'h1234,     2, 2};
        vecs[6]  = '{1'b0, 64'h0,    64'h0,  1, 64'hAAAA,     1'b1, 64'hAAAA,     2, 3};
        vecs[7]  = '{1'b0, 64'h200,  64'h0,  2, 64'hBBBB,     1'b1, 64'hBBBB,     2, 4};
        vecs[8]  = '{1'b0, 64'h0,    64'h0,  1, 64'hAAAA,     1'b1, 64'hAAAA,     2, 5};
        vecs[9]  = '{1'b0, 64'h0,    64'h0,  0, 64'h0,        1'b0, 64'hAAAA,     3, 5};
        vecs[10] = '{1'b0, 64'h1000, 64'h0,  1, 64'h55,       1'b1, 64'h55,       3, 6};
        vecs[11] = '{1'b0, 64'h100F, 64'h0,  2, 64'hF00D,     1'b1, 64'hF00D,     3, 7};

        reset        = 1'b1;
        dcache_en    = 1'b0;
        dcache_wren  = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        bus_ack      = 1'b0;
        bus_rdata    = '0;
        repeat (2) @(negedge clk);
        check("rst bus_req", bus_req, 1'b0);
        check("rst done", dcache_done, 1'b0);
        check("rst bus_addr", bus_addr, 64'h0);
        check("rst rdata", dcache_rdata, 64'h0);
        check("rst counters", {rd_hit_cnt, rd_miss_cnt}, 64'h0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

        // Reset two cycles into a read miss; the later ack must not fill or complete.
        @(negedge clk);
        dcache_en   = 1'b1;
        dcache_wren = 1'b0;
        dcache_addr = 64'h4000;
        @(negedge clk);
        dcache_en = 1'b0;
        check("abort req_up", bus_req, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort req_async", bus_req, 1'b0);
        check("abort counters", {rd_hit_cnt, rd_miss_cnt}, 64'h0);
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 64'h999;
        @(negedge clk);
        bus_ack = 1'b0;
        check("abort no_done", dcache_done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("abort no_done2", dcache_done, 1'b0);

        // 0x0 was cached before reset; it must miss now. A second request during RD_MISS is dropped.
        done_seen = 0;
        dcache_en   = 1'b1;
        dcache_addr = 64'h0;
        @(negedge clk);
        dcache_en = 1'b0;
        check("inval miss_req", bus_req, 1'b1);
        done_seen += int'(dcache_done);
        dcache_en   = 1'b1;
        dcache_addr = 64'h1000;
        @(negedge clk);
        dcache_en = 1'b0;
        done_seen += int'(dcache_done);
        bus_ack   = 1'b1;
        bus_rdata = 64'hAAAA;
        @(negedge clk);
        bus_ack = 1'b0;
        check("busy rdata", dcache_rdata, 64'hAAAA);
        for (int i = 0; i < 4; i++) begin
            done_seen += int'(dcache_done);
            @(negedge clk);
        end
        check("busy done_count", 64'(done_seen), 64'd1);
        check("busy miss_cnt", rd_miss_cnt, 32'd1);
        check("busy hit_cnt", rd_hit_cnt, 32'd0);
        check("busy no_req", bus_req, 1'b0);

        // Stray ack while idle must be ignored.
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("stray_ack done", dcache_done, 1'b0);
        check("stray_ack req", bus_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
